// File: rtl/main_mem_responder_if.sv
// Cache <-> main-memory request/response bundle.
// Master is the cache side; slave is the memory responder.
interface main_mem_responder_if;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        ready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        wack;

  modport master (
    output rd_req,
    output rd_addr,
    output wr_req,
    output wr_addr,
    output wr_data,
    input  ready,
    input  rdata,
    input  rvalid,
    input  wack
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    input  wr_req,
    input  wr_addr,
    input  wr_data,
    output ready,
    output rdata,
    output rvalid,
    output wack
  );
endinterface

// File: rtl/main_mem_responder.sv
// Main-memory responder: one outstanding refill/writeback at a
// time, fixed access latency, writeback serviced before refill.
module main_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  main_mem_responder_if.slave bus
);

  localparam int         DEPTH = 2 ** ADDR_W;
  localparam logic [7:0] LAT   = 8'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    WR_WAIT,
    RD_WAIT
  } state_e;

  state_e state_q, state_d;

  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [31:0]       wd_q, wd_d;
  logic              rd_pend_q, rd_pend_d;

  logic        rvalid_q, rvalid_d;
  logic        wack_q, wack_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [DEPTH];

  logic fire;
  logic accept;
  logic mem_we;

  // Upper address bits alias onto the array.
  logic unused_hi;
  assign unused_hi = ^{bus.rd_addr[31:ADDR_W],
                       bus.wr_addr[31:ADDR_W]};

  assign fire   = (state_q != IDLE) && (cnt_q == LAT);
  assign accept = (state_q == IDLE)
               && (bus.rd_req || bus.wr_req);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ra_q      <= '0;
      wa_q      <= '0;
      wd_q      <= '0;
      rd_pend_q <= 1'b0;
      rvalid_q  <= 1'b0;
      wack_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ra_q      <= ra_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      rd_pend_q <= rd_pend_d;
      rvalid_q  <= rvalid_d;
      wack_q    <= wack_d;
      rdata_q   <= rdata_d;
    end
  end

  // Storage is never reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wa_q] <= wd_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ra_d      = ra_q;
    wa_d      = wa_q;
    wd_d      = wd_q;
    rd_pend_d = rd_pend_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ra_d      = bus.rd_addr[ADDR_W-1:0];
          wa_d      = bus.wr_addr[ADDR_W-1:0];
          wd_d      = bus.wr_data;
          cnt_d     = 8'd1;
          rd_pend_d = bus.wr_req && bus.rd_req;
          state_d   = bus.wr_req ? WR_WAIT : RD_WAIT;
        end
      end
      WR_WAIT: begin
        if (fire) begin
          rd_pend_d = 1'b0;
          cnt_d     = rd_pend_q ? 8'd1 : 8'd0;
          state_d   = rd_pend_q ? RD_WAIT : IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RD_WAIT: begin
        if (fire) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wack_d   = 1'b0;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    mem_we   = 1'b0;
    if (fire && (state_q == WR_WAIT)) begin
      wack_d = 1'b1;
      mem_we = 1'b1;
    end
    if (fire && (state_q == RD_WAIT)) begin
      rvalid_d = 1'b1;
      rdata_d  = mem[ra_q];
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.rvalid = rvalid_q;
  assign bus.wack   = wack_q;
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: directed scenarios plus random
// traffic, checked each cycle against a transaction-level model.
module tb_main_mem_responder;

  localparam int AW  = 10;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  main_mem_responder_if bus ();

  main_mem_responder #(
    .ADDR_W (AW),
    .LATENCY(LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: requests become scheduled events in absolute cycles.
  logic [31:0] m [int];
  int  cyc = 0;
  bit  busy = 0;
  bit  was_busy;
  int  wack_at = -1, rv_at = -1, done_at = -1;
  int  m_ra, m_wa;
  logic [31:0] m_wd;
  bit  e_ready = 1, e_rv = 0, e_wack = 0, e_known = 1;
  logic [31:0] e_rdata = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy = 0;
      wack_at = -1;
      rv_at = -1;
      e_ready = 1;
      e_rv = 0;
      e_wack = 0;
      e_rdata = '0;
      e_known = 1;
    end else begin
      cyc++;
      was_busy = busy;
      e_wack = 0;
      e_rv = 0;
      if (busy && cyc == wack_at) begin
        m[m_wa] = m_wd;
        e_wack = 1;
      end
      if (busy && cyc == rv_at) begin
        e_rv = 1;
        if (m.exists(m_ra)) begin
          e_rdata = m[m_ra];
          e_known = 1;
        end else begin
          e_known = 0;
        end
      end
      if (busy && cyc == done_at) busy = 0;
      if (!was_busy && (bus.rd_req || bus.wr_req)) begin
        busy = 1;
        m_ra = int'(bus.rd_addr[AW-1:0]);
        m_wa = int'(bus.wr_addr[AW-1:0]);
        m_wd = bus.wr_data;
        wack_at = bus.wr_req ? cyc + LAT : -1;
        rv_at = !bus.rd_req ? -1 :
                bus.wr_req ? cyc + 2 * LAT : cyc + LAT;
        done_at = (rv_at > wack_at) ? rv_at : wack_at;
      end
      e_ready = !busy;
    end
  end

  int wack_cnt = 0, rv_cnt = 0;
  int last_wack = -1, last_rv = -1;

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("ready", 32'(bus.ready), 32'(e_ready));
      chk("rvalid", 32'(bus.rvalid), 32'(e_rv));
      chk("wack", 32'(bus.wack), 32'(e_wack));
      if (e_known) chk("rdata", bus.rdata, e_rdata);
    end
    if (bus.wack === 1'b1) begin
      wack_cnt++;
      last_wack = cyc;
    end
    if (bus.rvalid === 1'b1) begin
      rv_cnt++;
      last_rv = cyc;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready !== 1'b1) chk("ready_timeout", 0, 1);
  endtask

  task automatic req(bit r, logic [31:0] ra, bit w,
                     logic [31:0] wa, logic [31:0] wd,
                     output int acc);
    wait_ready();
    bus.rd_req  = r;
    bus.rd_addr = ra;
    bus.wr_req  = w;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    bus.rd_req = 0;
    bus.wr_req = 0;
  endtask

  int acc, rv0, w0;

  initial begin
    bus.rd_req  = 0;
    bus.wr_req  = 0;
    bus.rd_addr = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;

    // Reset and idle
    @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    repeat (2) @(negedge clk);
    reset = 1;
    chk("t1_ready", 32'(bus.ready), 1);
    chk("t1_rvalid", 32'(bus.rvalid), 0);
    chk("t1_wack", 32'(bus.wack), 0);
    chk("t1_rdata", bus.rdata, 0);
    repeat (10) @(negedge clk);
    chk("t1_pulses", wack_cnt + rv_cnt, 0);

    // Write then read
    req(0, 0, 1, 5, 32'hDEADBEEF, acc);
    wait_ready();
    chk("t2_wack_lat", last_wack - acc, LAT);
    req(1, 5, 0, 0, 0, acc);
    wait_ready();
    chk("t2_rv_lat", last_rv - acc, LAT);
    chk("t2_rdata", bus.rdata, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    chk("t2_hold", bus.rdata, 32'hDEADBEEF);

    // Simultaneous write+read, same address
    req(1, 7, 1, 7, 32'h12345678, acc);
    wait_ready();
    chk("t3_wack_lat", last_wack - acc, LAT);
    chk("t3_rv_lat", last_rv - acc, 2 * LAT);
    chk("t3_rdata", bus.rdata, 32'h12345678);

    // Request while busy is dropped
    rv0 = rv_cnt;
    req(1, 5, 0, 0, 0, acc);
    @(negedge clk);
    bus.rd_req  = 1;
    bus.rd_addr = 9;
    @(negedge clk);
    bus.rd_req = 0;
    repeat (24) @(negedge clk);
    chk("t4_rv_count", rv_cnt - rv0, 1);
    chk("t4_rv_lat", last_rv - acc, LAT);
    chk("t4_rdata", bus.rdata, 32'hDEADBEEF);

    // Reset in the middle of a writeback
    req(0, 0, 1, 3, 32'h11111111, acc);
    wait_ready();
    req(0, 0, 1, 3, 32'hAAAA5555, acc);
    w0 = wack_cnt;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 0;
    #1;
    chk("t5_ready", 32'(bus.ready), 1);
    chk("t5_wack", 32'(bus.wack), 0);
    chk("t5_rdata", bus.rdata, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    repeat (8) @(negedge clk);
    chk("t5_no_wack", wack_cnt - w0, 0);
    req(1, 3, 0, 0, 0, acc);
    wait_ready();
    chk("t5_rdata_old", bus.rdata, 32'h11111111);

    // Upper address bits ignored
    req(0, 0, 1, 32'h405, 32'hCAFEF00D, acc);
    wait_ready();
    req(1, 5, 0, 0, 0, acc);
    wait_ready();
    chk("t6_alias", bus.rdata, 32'hCAFEF00D);

    // Random traffic, requests driven regardless of ready
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      bus.rd_req  = ($urandom % 4) == 0;
      bus.wr_req  = ($urandom % 4) == 0;
      bus.rd_addr = ($urandom & 32'hFFFF_FC00)
                  | 32'($urandom_range(0, 15));
      bus.wr_addr = ($urandom & 32'hFFFF_FC00)
                  | 32'($urandom_range(0, 15));
      bus.wr_data = $urandom;
      if (i == 1200) begin
        #2 reset = 0;
        @(negedge clk);
        reset = 1;
      end
    end
    @(negedge clk);
    bus.rd_req = 0;
    bus.wr_req = 0;
    wait_ready();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/main_mem_responder.md
Name: main_mem_responder

Overview:
- Main-memory side of the cache/memory interface; services one outstanding cache request at a time.
- Request types:
  - Refill read after a cache miss.
  - Dirty-line writeback on eviction.
- Holds a word-addressed storage array behind a fixed access latency.
- Returns refill data with a one-cycle valid pulse, which the cache consumes as its write-next input, and acknowledges writebacks.

Parameters:
- ADDR_W, 10, width of word index; storage depth is 2**ADDR_W 32-bit words.
- LATENCY, 4, cycles from request acceptance to response; legal range 1..255; 0 is illegal.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- rd_req  input  1  refill read request; sampled only while ready=1.
- rd_addr  input  32  refill word address; bits [ADDR_W-1:0] used, upper bits ignored.
- wr_req  input  1  writeback request; sampled only while ready=1.
- wr_addr  input  32  writeback word address; same bit usage as rd_addr.
- wr_data  input  32  writeback data word, full word, no byte enables.
- ready  output  1  1 = idle, requests accepted at next rising edge.
- rdata  output  32  refill data; valid when rvalid=1; holds last value otherwise.
- rvalid  output  1  one-cycle pulse: rdata carries refill data.
- wack  output  1  one-cycle pulse: writeback committed to storage.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: ready=1, rvalid=0, wack=0, rdata=0.
  - Internal: state=IDLE, latency counter=0, latched request cleared.
  - Storage contents are not cleared and not required to be initialised.
- Acceptance:
  - At rising edge T with ready=1 and rd_req and/or wr_req=1, latch addresses, data and request type(s).
  - ready drops to 0 from T onward.
  - Requests while ready=0 are ignored entirely: no queueing, no side effects.
- FSM states:
  - IDLE: ready=1. wr_req → WR_WAIT. rd_req only → RD_WAIT. Both asserted → WR_WAIT with read pending.
  - WR_WAIT: counter counts LATENCY cycles. At edge T+LATENCY: storage[wr_addr] ← wr_data, wack=1 for one cycle. Then → RD_WAIT if a read is pending, else → IDLE with ready=1 at that same edge.
  - RD_WAIT: counter counts LATENCY cycles from entry. At the final edge: rdata ← storage[rd_addr], rvalid=1 for one cycle, → IDLE, ready=1 at that same edge.
- Latency:
  - Read-only: rvalid at T+LATENCY.
  - Write-only: wack at T+LATENCY.
  - Read+write: wack at T+LATENCY, rvalid at T+2*LATENCY.
  - Earliest next acceptance is the edge after ready returns to 1, so back-to-back requests cost LATENCY+1 cycles.
- Ordering: the write is always serviced before the read, so a same-address simultaneous pair returns the newly written data (writeback-before-refill consistency).
- Counter width: 8 bits. It loads on state entry and the response fires when it reaches LATENCY.
- rvalid and wack are never asserted in the same cycle, and never while ready=1 was already 1 the previous cycle.
- Reset mid-operation:
  - Pending request dropped; no wack/rvalid issued.
  - A storage write not yet reached its commit edge is not performed.
- Upper address bits are ignored; aliasing wraps modulo 2**ADDR_W.

Test Plan:
1. Reset with reset=0 for 3 cycles, release → ready=1, rvalid=0, wack=0, rdata=0; no pulses for 10 idle cycles.
2. LATENCY=4: write addr 5 data 0xDEADBEEF at edge T → ready=0 T..T+3, wack=1 only at T+4, ready=1 at T+4. Then read addr 5 at edge U → rvalid=1 only at U+4, rdata=0xDEADBEEF, rdata held afterwards.
3. Simultaneous wr_req addr 7 data 0x12345678 and rd_req addr 7 at edge T → wack at T+4, rvalid at T+8 with rdata=0x12345678, ready=1 at T+8.
4. Read addr 5 accepted at T; rd_req addr 9 asserted at T+2 while ready=0 → exactly one rvalid (T+4, 0xDEADBEEF); no further rvalid within 20 cycles.
5. storage[3]=0x11111111. Write addr 3 data 0xAAAA5555 at T, reset=0 asserted mid-cycle at T+2 → outputs reset immediately, no wack. After release, read addr 3 returns 0x11111111.
6. ADDR_W=10: write addr 0x00000405 data 0xCAFEF00D, then read addr 0x00000005 → rdata=0xCAFEF00D (upper bits ignored).
